edge_period_counter: RTL and testbench

//   Consumes the single-cycle POSEDGE pulse produced by pos_edge_detector (e.g. 1PPS or a

---
 rtl/edge_period_counter.sv | 126 ++++++++++++
 tb/tb_edge_period_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/edge_period_counter.sv
// Measures clock cycles between accepted reference pulses, rejects glitches,
// flags loss of reference by timeout and tracks period stability for a lock indication.
`timescale 1ns/1ps
module edge_period_counter #(
    parameter int unsigned CNT_WIDTH      = 24,
    parameter int unsigned TIMEOUT_CYCLES = 3_604_480,
    parameter int unsigned MIN_PERIOD     = 1_024,
    parameter int unsigned TOL_CYCLES     = 32,
    parameter int unsigned LOCK_COUNT     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 posedge_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic                 period_valid_o,
    output logic                 timeout_o,
    output logic                 locked_o
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] TimeoutCnt = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] MinPeriod  = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] TolCycles  = CNT_WIDTH'(TOL_CYCLES);
    localparam logic [MW-1:0]        LockMax    = MW'(LOCK_COUNT);
    localparam longint unsigned      CntMax     = (64'd1 << CNT_WIDTH) - 64'd1;

    // The counter must be able to reach the timeout value without wrapping.
    if (64'(TIMEOUT_CYCLES) > CntMax) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES does not fit in CNT_WIDTH bits");
    end
    if (MIN_PERIOD > TIMEOUT_CYCLES) begin : g_bad_min_period
        $error("MIN_PERIOD must not exceed TIMEOUT_CYCLES");
    end

    typedef enum logic {
        WAIT_FIRST,
        MEASURE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic [MW-1:0]          match_q, match_d;
    logic [CNT_WIDTH-1:0]   prev_q, prev_d;
    logic                   prev_valid_q, prev_valid_d;
    logic [CNT_WIDTH-1:0]   diff;

    assign diff = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        timeout_d    = 1'b0;
        match_d      = match_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;

        unique case (state_q)
            WAIT_FIRST: begin
                if (posedge_i) begin
                    state_d      = MEASURE;
                    cnt_d        = CNT_WIDTH'(1);
                    match_d      = '0;
                    prev_valid_d = 1'b0;
                end
            end
            MEASURE: begin
                // A pulse at exactly the timeout count is accepted, since MinPeriod <= TimeoutCnt.
                if (posedge_i && (cnt_q >= MinPeriod)) begin
                    period_d     = cnt_q;
                    valid_d      = 1'b1;
                    cnt_d        = CNT_WIDTH'(1);
                    prev_d       = cnt_q;
                    prev_valid_d = 1'b1;
                    if (!prev_valid_q) begin
                        match_d = '0;
                    end else if (diff <= TolCycles) begin
                        match_d = (match_q == LockMax) ? match_q : match_q + MW'(1);
                    end else begin
                        match_d = '0;
                    end
                end else if (cnt_q == TimeoutCnt) begin
                    state_d      = WAIT_FIRST;
                    cnt_d        = '0;
                    timeout_d    = 1'b1;
                    match_d      = '0;
                    prev_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= WAIT_FIRST;
            cnt_q        <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            match_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            match_q      <= match_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign timeout_o      = timeout_q;
    assign locked_o       = (match_q == LockMax);

endmodule

// File: tb/tb_edge_period_counter.sv
// Directed, table-driven bench for edge_period_counter: pulse spacing records with
// hand-computed strobe, period and lock expectations, plus timeout and reset sequences.
`timescale 1ns/1ps
module tb_edge_period_counter;

    localparam int CW  = 24;
    localparam int TO  = 1000;
    localparam int MP  = 10;
    localparam int TOL = 2;
    localparam int LC  = 3;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          posedge_i;
    logic [CW-1:0] period_o;
    logic          period_valid_o;
    logic          timeout_o;
    logic          locked_o;

    int nCompared   = 0;
    int nMismatched = 0;

    // gap: cycles from the previous pulse (or from reset/timeout) to this pulse
    typedef struct {
        int gap;
        bit expValid;
        int expPeriod;
        bit expLocked;
    } vec_t;

    vec_t vecsA[20];
    vec_t vecsB[3];
    vec_t vecsC[2];

    edge_period_counter #(
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TO),
        .MIN_PERIOD     (MP),
        .TOL_CYCLES     (TOL),
        .LOCK_COUNT     (LC)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .posedge_i      (posedge_i),
        .period_o       (period_o),
        .period_valid_o (period_valid_o),
        .timeout_o      (timeout_o),
        .locked_o       (locked_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " period"}, int'(period_o), 0);
        checkOutput({tag, " valid"}, int'(period_valid_o), 0);
        checkOutput({tag, " timeout"}, int'(timeout_o), 0);
        checkOutput({tag, " locked"}, int'(locked_o), 0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int spurious;
        spurious  = 0;
        posedge_i = 1'b0;
        for (int i = 1; i < v.gap; i++) begin
            tick();
            if (period_valid_o || timeout_o) spurious++;
        end
        posedge_i = 1'b1;
        tick();
        posedge_i = 1'b0;
        checkOutput({tag, " idle strobes"}, spurious, 0);
        checkOutput({tag, " valid"}, int'(period_valid_o), int'(v.expValid));
        checkOutput({tag, " period"}, int'(period_o), v.expPeriod);
        checkOutput({tag, " locked"}, int'(locked_o), int'(v.expLocked));
        checkOutput({tag, " timeout"}, int'(timeout_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        bit seen;

        vecsA[0]  = '{5,   1'b0, 0,   1'b0};
        vecsA[1]  = '{100, 1'b1, 100, 1'b0};
        vecsA[2]  = '{100, 1'b1, 100, 1'b0};
        vecsA[3]  = '{100, 1'b1, 100, 1'b0};
        vecsA[4]  = '{100, 1'b1, 100, 1'b1};
        vecsA[5]  = '{100, 1'b1, 100, 1'b1};
        vecsA[6]  = '{101, 1'b1, 101, 1'b1};
        vecsA[7]  = '{99,  1'b1, 99,  1'b1};
        vecsA[8]  = '{102, 1'b1, 102, 1'b0};
        vecsA[9]  = '{102, 1'b1, 102, 1'b0};
        vecsA[10] = '{102, 1'b1, 102, 1'b0};
        vecsA[11] = '{102, 1'b1, 102, 1'b1};
        vecsA[12] = '{5,   1'b0, 102, 1'b1};
        vecsA[13] = '{95,  1'b1, 100, 1'b1};
        vecsA[14] = '{9,   1'b0, 100, 1'b1};
        vecsA[15] = '{1,   1'b1, 10,  1'b0};
        vecsA[16] = '{100, 1'b1, 100, 1'b0};
        vecsA[17] = '{100, 1'b1, 100, 1'b0};
        vecsA[18] = '{100, 1'b1, 100, 1'b0};
        vecsA[19] = '{100, 1'b1, 100, 1'b1};

        vecsB[0]  = '{20,   1'b0, 100,  1'b0};
        vecsB[1]  = '{100,  1'b1, 100,  1'b0};
        vecsB[2]  = '{1000, 1'b1, 1000, 1'b0};

        vecsC[0]  = '{30,  1'b0, 0,   1'b0};
        vecsC[1]  = '{100, 1'b1, 100, 1'b0};

        rst_n_i   = 1'b0;
        posedge_i = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rst_n_i = 1'b1;

        for (int i = 0; i < 20; i++) applyStimulus(vecsA[i], $sformatf("A%0d", i));

        // Reference lost: strobe expected 1001 cycles after the last accepted pulse.
        k    = 1;
        seen = 1'b0;
        while (!seen && k < 1200) begin
            tick();
            k++;
            if (timeout_o) seen = 1'b1;
        end
        checkOutput("timeout seen", int'(seen), 1);
        checkOutput("timeout cycle", k, 1001);
        checkOutput("timeout locked", int'(locked_o), 0);
        checkOutput("timeout valid", int'(period_valid_o), 0);
        tick();
        checkOutput("timeout one-cycle", int'(timeout_o), 0);

        for (int i = 0; i < 3; i++) applyStimulus(vecsB[i], $sformatf("B%0d", i));

        // Reset 50 cycles into a period must drop all history.
        repeat (49) tick();
        rst_n_i = 1'b0;
        tick();
        checkAllZero("midreset");
        rst_n_i = 1'b1;

        for (int i = 0; i < 2; i++) applyStimulus(vecsC[i], $sformatf("C%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
